// File: rtl/multicycle_controller_pkg.sv
// Shared constants for the multi-cycle MIPS control unit: state encodings,
// opcode/funct values, ALU operation codes and datapath select values.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_JUMP   = 4'd12
  } state_e;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_controller_if.sv
// Shared instruction/data memory handshake. mem_req, mem_write and iord are
// held stable from request until the cycle mem_ready is high; that cycle completes it.
interface multicycle_controller_if;
  logic mem_req;
  logic mem_write;
  logic iord;
  logic mem_ready;

  modport master (output mem_req, output mem_write, output iord, input mem_ready);
  modport slave  (input mem_req, input mem_write, input iord, output mem_ready);
endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// R-type funct field to ALU operation, with a flag for functs this core supports.
module alu_decoder
  import ctrl_pkg::*;
(
  input  logic [5:0] funct_i,
  output logic [2:0] alu_ctrl_o,
  output logic       legal_o
);
  always_comb begin
    alu_ctrl_o = ALU_ADD;
    legal_o    = 1'b1;
    case (funct_i)
      FN_ADD:  alu_ctrl_o = ALU_ADD;
      FN_SUB:  alu_ctrl_o = ALU_SUB;
      FN_AND:  alu_ctrl_o = ALU_AND;
      FN_OR:   alu_ctrl_o = ALU_OR;
      FN_SLT:  alu_ctrl_o = ALU_SLT;
      default: legal_o    = 1'b0;
    endcase
  end
endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// and drives datapath selects, strobes, memory requests and the ALU op code.
module multicycle_controller
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_en,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_ctrl,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       illegal,
  output logic [3:0] state_o
);
  state_e     state_q, state_d;
  logic       arm_q;
  logic [2:0] dec_alu;
  logic       dec_legal;

  alu_decoder u_alu_dec (
    .funct_i   (funct),
    .alu_ctrl_o(dec_alu),
    .legal_o   (dec_legal)
  );

  // arm_q spends the first edge after reset release so IDLE lasts one full cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      arm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      arm_q   <= 1'b1;
    end
  end

  assign state_o = state_q;

  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_en      = 1'b0;
    pc_src     = PCSRC_ALU;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_B;
    alu_ctrl   = ALU_AND;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      S_IDLE: if (arm_q) state_d = S_FETCH;
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRCB_FOUR;
        alu_ctrl  = ALU_ADD;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMMSH;
        alu_ctrl  = ALU_ADD;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          OP_R: begin
            if (dec_legal) begin
              state_d = S_EXEC;
            end else begin
              illegal = 1'b1;
              state_d = S_FETCH;
            end
          end
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_ctrl  = ALU_ADD;
        state_d   = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_ctrl  = dec_alu;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_ctrl  = ALU_SUB;
        pc_src    = PCSRC_ALUOUT;
        pc_en     = zero;
        state_d   = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_ctrl  = ALU_ADD;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        pc_src  = PCSRC_JUMP;
        pc_en   = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed and random instruction streams
// checked cycle by cycle against an instruction-level reference model.
module tb_multicycle_controller;

  typedef struct packed {
    logic [3:0] st;
    logic       req, wr, io, irw, pce;
    logic [1:0] pcs;
    logic       sa;
    logic [1:0] sb;
    logic [2:0] alu;
    logic       rw, rd, m2r, ill;
  } vec_t;

  logic       clk = 1'b0;
  logic       resetn;
  logic [5:0] opcode, funct;
  logic       zero;
  logic       ir_write, pc_en, alu_src_a, reg_write, reg_dst, mem_to_reg, illegal;
  logic [1:0] pc_src, alu_src_b;
  logic [2:0] alu_ctrl;
  logic [3:0] state_o;

  multicycle_controller_if mif ();

  multicycle_controller dut (
    .clk       (clk),
    .resetn    (resetn),
    .opcode    (opcode),
    .funct     (funct),
    .zero      (zero),
    .mem_ready (mif.mem_ready),
    .mem_req   (mif.mem_req),
    .mem_write (mif.mem_write),
    .iord      (mif.iord),
    .ir_write  (ir_write),
    .pc_en     (pc_en),
    .pc_src    (pc_src),
    .alu_src_a (alu_src_a),
    .alu_src_b (alu_src_b),
    .alu_ctrl  (alu_ctrl),
    .reg_write (reg_write),
    .reg_dst   (reg_dst),
    .mem_to_reg(mem_to_reg),
    .illegal   (illegal),
    .state_o   (state_o)
  );

  always #5 clk = ~clk;

  vec_t obs;
  assign obs = {state_o, mif.mem_req, mif.mem_write, mif.iord, ir_write, pc_en, pc_src,
                alu_src_a, alu_src_b, alu_ctrl, reg_write, reg_dst, mem_to_reg, illegal};

  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t exp_q[$];
  bit   rdy_q[$];
  bit   zr_q[$];

  function automatic bit rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic bit op_legal(input logic [5:0] op);
    return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
  endfunction

  function automatic bit fn_legal(input logic [5:0] fn);
    return fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  endfunction

  function automatic logic [2:0] fn_alu(input logic [5:0] fn);
    logic [2:0] r;
    r = 3'b010;
    if (fn == 6'b100010) r = 3'b110;
    if (fn == 6'b100100) r = 3'b000;
    if (fn == 6'b100101) r = 3'b001;
    if (fn == 6'b101010) r = 3'b111;
    return r;
  endfunction

  task automatic check(input string tag, input vec_t o, input vec_t e);
    n_tests++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h required %h (state %0d vs %0d)", tag, o, e, o.st, e.st);
    end
  endtask

  task automatic push(input vec_t v, input bit rdy, input bit zr);
    exp_q.push_back(v);
    rdy_q.push_back(rdy);
    zr_q.push_back(zr);
  endtask

  // One memory access: w stall cycles then the ready cycle. ready_v is the
  // vector for the completing cycle (fetch strobes differ only there).
  task automatic mem_access(input vec_t stall_v, input vec_t ready_v, input int w);
    for (int i = 0; i < w; i++) push(stall_v, 1'b0, rbit());
    push(ready_v, 1'b1, rbit());
  endtask

  // Reference: expand one instruction into its expected per-cycle outputs.
  task automatic model_instr(input logic [5:0] op, input logic [5:0] fn, input bit z,
                             input int wf, input int wm);
    vec_t v, r;
    bit   ill;
    v = '0; v.st = 4'd1; v.req = 1'b1; v.sb = 2'b01; v.alu = 3'b010;
    r = v; r.irw = 1'b1; r.pce = 1'b1;
    mem_access(v, r, wf);
    ill = !op_legal(op) || (op == 6'b000000 && !fn_legal(fn));
    v = '0; v.st = 4'd2; v.sb = 2'b11; v.alu = 3'b010; v.ill = ill;
    push(v, rbit(), rbit());
    if (!ill) begin
      if (op == 6'b100011 || op == 6'b101011) begin
        v = '0; v.st = 4'd3; v.sa = 1'b1; v.sb = 2'b10; v.alu = 3'b010;
        push(v, rbit(), rbit());
        if (op == 6'b100011) begin
          v = '0; v.st = 4'd4; v.req = 1'b1; v.io = 1'b1;
          mem_access(v, v, wm);
          v = '0; v.st = 4'd5; v.rw = 1'b1; v.m2r = 1'b1;
          push(v, rbit(), rbit());
        end else begin
          v = '0; v.st = 4'd6; v.req = 1'b1; v.wr = 1'b1; v.io = 1'b1;
          mem_access(v, v, wm);
        end
      end else if (op == 6'b000000) begin
        v = '0; v.st = 4'd7; v.sa = 1'b1; v.alu = fn_alu(fn);
        push(v, rbit(), rbit());
        v = '0; v.st = 4'd8; v.rw = 1'b1; v.rd = 1'b1;
        push(v, rbit(), rbit());
      end else if (op == 6'b000100) begin
        v = '0; v.st = 4'd9; v.sa = 1'b1; v.alu = 3'b110; v.pcs = 2'b01; v.pce = z;
        push(v, rbit(), z);
      end else if (op == 6'b001000) begin
        v = '0; v.st = 4'd10; v.sa = 1'b1; v.sb = 2'b10; v.alu = 3'b010;
        push(v, rbit(), rbit());
        v = '0; v.st = 4'd11; v.rw = 1'b1;
        push(v, rbit(), rbit());
      end else begin
        v = '0; v.st = 4'd12; v.pcs = 2'b10; v.pce = 1'b1;
        push(v, rbit(), rbit());
      end
    end
  endtask

  // Drive queued cycles: inputs set just after posedge, outputs sampled on negedge.
  task automatic run_q(input string tag);
    vec_t e;
    while (exp_q.size() > 0) begin
      e         = exp_q.pop_front();
      mif.mem_ready = rdy_q.pop_front();
      zero      = zr_q.pop_front();
      @(negedge clk);
      check(tag, obs, e);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                          input bit z, input int wf, input int wm);
    opcode = op;
    funct  = fn;
    model_instr(op, fn, z, wf, wm);
    run_q(tag);
  endtask

  task automatic push_idle2();
    vec_t v;
    v = '0;
    push(v, rbit(), rbit());
    push(v, rbit(), rbit());
  endtask

  initial begin
    logic [5:0] legal_fn [5];
    logic [5:0] op, fn;
    vec_t       zv, fv;
    int         kind;
    legal_fn[0] = 6'b100000; legal_fn[1] = 6'b100010; legal_fn[2] = 6'b100100;
    legal_fn[3] = 6'b100101; legal_fn[4] = 6'b101010;
    zv = '0;

    resetn = 1'b0; opcode = 6'b100011; funct = 6'b0; zero = 1'b1; mif.mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold", obs, zv);
    resetn = 1'b1;
    push_idle2();
    run_q("reset_release");
    do_instr("lw_first", 6'b100011, 6'b0, 1'b0, 0, 0);

    // Reset asserted while FETCH is stalled, held for three cycles.
    fv = '0; fv.st = 4'd1; fv.req = 1'b1; fv.sb = 2'b01; fv.alu = 3'b010;
    push(fv, 1'b0, 1'b0);
    run_q("fetch_before_reset");
    mif.mem_ready = 1'b1; zero = 1'b1;
    resetn = 1'b0;
    #1;
    check("reset_async", obs, zv);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_low", obs, zv);
      @(posedge clk);
      #1;
    end
    resetn = 1'b1;
    push_idle2();
    run_q("reset_release2");
    do_instr("lw_after_reset", 6'b100011, 6'b0, 1'b0, 0, 0);

    for (int i = 0; i < 5; i++) do_instr("r_type", 6'b000000, legal_fn[i], 1'b0, 0, 0);
    do_instr("beq_taken", 6'b000100, 6'b0, 1'b1, 0, 0);
    do_instr("beq_not_taken", 6'b000100, 6'b0, 1'b0, 0, 0);
    do_instr("sw_waits", 6'b101011, 6'b0, 1'b0, 3, 3);
    do_instr("lw_waits", 6'b100011, 6'b0, 1'b0, 3, 3);
    do_instr("illegal_op", 6'b111111, 6'b0, 1'b0, 0, 0);
    do_instr("illegal_funct", 6'b000000, 6'b000111, 1'b0, 0, 0);
    do_instr("jump", 6'b000010, 6'b0, 1'b0, 0, 0);
    do_instr("addi", 6'b001000, 6'b0, 1'b0, 0, 0);

    for (int n = 0; n < 60; n++) begin
      kind = int'($urandom_range(0, 7));
      fn   = 6'($urandom_range(0, 63));
      case (kind)
        0: op = 6'b100011;
        1: op = 6'b101011;
        2: begin op = 6'b000000; fn = legal_fn[$urandom_range(0, 4)]; end
        3: op = 6'b000000;
        4: op = 6'b000100;
        5: op = 6'b001000;
        6: op = 6'b000010;
        default: op = 6'($urandom_range(0, 63));
      endcase
      do_instr("random", op, fn, rbit(), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
